wb_mem_arbiter: RTL and testbench
=================================

# wb_mem_arbiter

Two-master Wishbone arbiter that shares the single SECDED main-memory emulator port between the instruction-fetch master (m0) and the data master (m1). Grants are round-robin, held for the whole `cyc` of the granted master, so bursts (including 8-beat incrementing bursts) are never split. A watchdog terminates stalled transfers with `err` so a hung slave cannot lock the core. The block sits between the core's bus masters and the memory emulator's slave port.

## Interface
- `TIMEOUT`, default 64: cycles with slave `stb` high and no `ack`/`err`/`rty` before the watchdog fires; range 2..255.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_wb_cyc_o`, `m0_wb_stb_o`, `m0_wb_we_o` in 1 each: master 0 cycle, strobe, write enable.
- `m0_wb_adr_o` in 32, `m0_wb_dat_o` in 32, `m0_wb_sel_o` in 4, `m0_wb_cti_o` in 3, `m0_wb_bte_o` in 2: master 0 request fields.
- `m0_wb_dat_i` out 32, `m0_wb_ack_i`, `m0_wb_err_i`, `m0_wb_rty_i` out 1 each: master 0 responses.
- `m1_*`: identical port set for master 1.
- `s_wb_cyc_o`, `s_wb_stb_o`, `s_wb_we_o` out 1 each, plus `s_wb_adr_o` 32, `s_wb_dat_o` 32, `s_wb_sel_o` 4, `s_wb_cti_o` 3, `s_wb_bte_o` 2, all out: slave request.
- `s_wb_dat_i` in 32, `s_wb_ack_i`, `s_wb_err_i`, `s_wb_rty_i` in 1 each: slave responses.
- `grant` out 2: one-hot current owner; 00 means idle.
- `timeout_evt` out 1: one-cycle pulse when the watchdog fires.

## Operation
- State machine:
  - States: IDLE, GNT0, GNT1. Reset enters IDLE.
  - Priority pointer `last` resets to 1, so master 0 wins the first tie.
- IDLE transitions (a request is `mX_wb_cyc_o`):
  - Only one master requesting: go to that master's GNT.
  - Both requesting: grant the master not equal to `last`.
- GNTx transitions:
  - Stay while `mx_wb_cyc_o` is high.
  - When it drops: go to GNTy if the other master's `cyc` is high, else IDLE.
  - Set `last` to x.
- Slave request outputs:
  - In GNTx: the `s_wb_*` request outputs copy master x combinationally.
  - In IDLE: all request outputs are 0.
- Master response outputs:
  - `s_wb_dat_i` is broadcast to both `mX_wb_dat_i`.
  - `ack`/`err`/`rty` go only to the granted master; the non-granted master sees 0.
- Watchdog:
  - 8-bit counter. Clears on IDLE, on any slave `ack`/`err`/`rty`, or when `s_wb_stb_o` is low.
  - Increments otherwise.
  - When it reaches `TIMEOUT`: the granted master gets `err=1` for exactly one cycle, `timeout_evt` pulses, the counter clears, and `s_wb_stb_o` is forced low that cycle.
  - A slave response arriving in the same cycle as the watchdog hit wins, and no error is raised.
- Reset, including mid-burst: state returns to IDLE, `last` to 1, and the counter to 0. All outputs are 0 on the following cycle.

## Timing
- Grant latency: a `cyc` rising in cycle N (state IDLE) gives `grant` and slave `cyc` in cycle N+1. No grant is issued in cycle N.
- Handover: a `cyc` drop in cycle N gives the other master its grant in cycle N+1, with zero idle cycles.
- The response path is purely combinational: slave `ack` in cycle N reaches the granted master in cycle N.
- Bursts: `cti`/`bte` pass through untouched. A master holding `cyc` across beats keeps the grant regardless of the other master's requests.
- Reset values: every output is 0; `grant` = 00.

## Structure
- Shared package `wb_arb_pkg`:
  - State encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10).
  - Wishbone CTI constants: CLASSIC=3'b000, INCR=3'b010, EOB=3'b111.
- Sub-module `wb_arb_watchdog`:
  - Inputs: `clk`, `rst`, `active`, `stb`, `resp`.
  - Output: `fire`.
  - Holds the counter and the `TIMEOUT` compare.
- Top level holds the FSM, the `last` pointer and the muxes.

## Test plan
- **Single master:** m0 classic read of 0x0000_0100, slave acks with 0xDEADBEEF → `grant`=01 one cycle after `cyc`; m0 gets ack plus the data; m1 ack stays 0.
- **Simultaneous requests:** m0 and m1 raise `cyc` in the same cycle after reset → m0 served first; m1 granted the cycle after m0 drops `cyc`, with no IDLE cycle between.
- **Fairness:** both masters request continuously for 6 single transfers → grants alternate 0,1,0,1,0,1.
- **Burst integrity:** m1 runs an 8-beat INCR burst (`cti` 010…111) while m0 requests mid-burst → all 8 acks go to m1; m0 is granted only after m1's `cyc` drops.
- **Timeout:** `TIMEOUT`=16, slave never acks → m0 gets `err` and `timeout_evt` exactly in the 16th stalled cycle, one cycle wide. A slave ack arriving in that same cycle → no `err`.
- **Reset mid-burst:** `rst` asserted in beat 3 of an m0 burst → next cycle `grant`=00, all slave outputs 0, and the next tie goes to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone memory arbiter.
//   arb_state_t : arbiter FSM state; the encoding doubles as the one-hot grant
//   CLASSIC/INCR/EOB : Wishbone cycle-type identifier values
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbitrated slave port.
//   clk, rst : clock, synchronous active-high reset
//   active   : a master currently owns the bus
//   stb      : granted master's strobe (before any watchdog forcing)
//   resp     : slave ack | err | rty
//   fire     : combinational, high in the TIMEOUT-th consecutive stalled cycle
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic resp,
  output logic fire
);
  import wb_arb_pkg::*;

  // The first stalled cycle sees count==0, so the TIMEOUT-th one sees TIMEOUT-1.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // A slave response in the same cycle wins over the watchdog.
  assign fire = active && stb && !resp && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!active || !stb || resp || fire) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between master 0
// (instruction fetch) and master 1 (data). A grant is held for the whole cyc
// of the owner; a watchdog ends stalled transfers with err.
//   clk, rst        : clock, synchronous active-high reset
//   m0_wb_*, m1_wb_*: master request inputs (*_o) and response outputs (*_i)
//   s_wb_*          : slave request outputs (*_o) and response inputs (*_i)
//   grant           : one-hot owner, 00 when idle
//   timeout_evt     : one-cycle pulse when the watchdog fires
module wb_mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_wb_cyc_o,
  input  logic        m0_wb_stb_o,
  input  logic        m0_wb_we_o,
  input  logic [31:0] m0_wb_adr_o,
  input  logic [31:0] m0_wb_dat_o,
  input  logic [3:0]  m0_wb_sel_o,
  input  logic [2:0]  m0_wb_cti_o,
  input  logic [1:0]  m0_wb_bte_o,
  output logic [31:0] m0_wb_dat_i,
  output logic        m0_wb_ack_i,
  output logic        m0_wb_err_i,
  output logic        m0_wb_rty_i,
  input  logic        m1_wb_cyc_o,
  input  logic        m1_wb_stb_o,
  input  logic        m1_wb_we_o,
  input  logic [31:0] m1_wb_adr_o,
  input  logic [31:0] m1_wb_dat_o,
  input  logic [3:0]  m1_wb_sel_o,
  input  logic [2:0]  m1_wb_cti_o,
  input  logic [1:0]  m1_wb_bte_o,
  output logic [31:0] m1_wb_dat_i,
  output logic        m1_wb_ack_i,
  output logic        m1_wb_err_i,
  output logic        m1_wb_rty_i,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [2:0]  s_wb_cti_o,
  output logic [1:0]  s_wb_bte_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  input  logic        s_wb_rty_i,
  output logic [1:0]  grant,
  output logic        timeout_evt
);
  import wb_arb_pkg::*;

  arb_state_t state, state_nxt;
  logic       last, last_nxt;   // last master released: 0 = m0, 1 = m1
  logic       gnt0, gnt1;
  logic       stb_raw;
  logic       resp;
  logic       fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_wb_cyc_o && m1_wb_cyc_o) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (m0_wb_cyc_o) begin
          state_nxt = GNT0;
        end else if (m1_wb_cyc_o) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_wb_cyc_o) begin
          last_nxt  = 1'b0;
          state_nxt = m1_wb_cyc_o ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_wb_cyc_o) begin
          last_nxt  = 1'b1;
          state_nxt = m0_wb_cyc_o ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt0  = (state == GNT0);
  assign gnt1  = (state == GNT1);
  assign grant = {gnt1, gnt0};

  always_comb begin
    s_wb_cyc_o = 1'b0;
    stb_raw    = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    s_wb_cti_o = '0;
    s_wb_bte_o = '0;
    if (gnt0) begin
      s_wb_cyc_o = m0_wb_cyc_o;
      stb_raw    = m0_wb_stb_o;
      s_wb_we_o  = m0_wb_we_o;
      s_wb_adr_o = m0_wb_adr_o;
      s_wb_dat_o = m0_wb_dat_o;
      s_wb_sel_o = m0_wb_sel_o;
      s_wb_cti_o = m0_wb_cti_o;
      s_wb_bte_o = m0_wb_bte_o;
    end else if (gnt1) begin
      s_wb_cyc_o = m1_wb_cyc_o;
      stb_raw    = m1_wb_stb_o;
      s_wb_we_o  = m1_wb_we_o;
      s_wb_adr_o = m1_wb_adr_o;
      s_wb_dat_o = m1_wb_dat_o;
      s_wb_sel_o = m1_wb_sel_o;
      s_wb_cti_o = m1_wb_cti_o;
      s_wb_bte_o = m1_wb_bte_o;
    end
  end

  assign resp = s_wb_ack_i | s_wb_err_i | s_wb_rty_i;

  // The watchdog sees the unforced strobe so the forced-low cycle does not
  // feed back into its own fire condition.
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (gnt0 | gnt1),
    .stb    (stb_raw),
    .resp   (resp),
    .fire   (fire)
  );

  assign s_wb_stb_o  = stb_raw & ~fire;
  assign timeout_evt = fire;

  assign m0_wb_dat_i = s_wb_dat_i;
  assign m1_wb_dat_i = s_wb_dat_i;
  assign m0_wb_ack_i = gnt0 & s_wb_ack_i;
  assign m0_wb_err_i = gnt0 & (s_wb_err_i | fire);
  assign m0_wb_rty_i = gnt0 & s_wb_rty_i;
  assign m1_wb_ack_i = gnt1 & s_wb_ack_i;
  assign m1_wb_err_i = gnt1 & (s_wb_err_i | fire);
  assign m1_wb_rty_i = gnt1 & s_wb_rty_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed master transfers against a
// registered-ack slave model; a monitor compares responses and grant changes
// against expectation queues filled by the stimulus.
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_wb_cyc_o = 0, m0_wb_stb_o = 0, m0_wb_we_o = 0;
  logic [31:0] m0_wb_adr_o = '0, m0_wb_dat_o = 32'h1111_1111;
  logic [3:0]  m0_wb_sel_o = 4'hF;
  logic [2:0]  m0_wb_cti_o = '0;
  logic [1:0]  m0_wb_bte_o = '0;
  logic [31:0] m0_wb_dat_i;
  logic        m0_wb_ack_i, m0_wb_err_i, m0_wb_rty_i;
  logic        m1_wb_cyc_o = 0, m1_wb_stb_o = 0, m1_wb_we_o = 0;
  logic [31:0] m1_wb_adr_o = '0, m1_wb_dat_o = 32'h2222_2222;
  logic [3:0]  m1_wb_sel_o = 4'hF;
  logic [2:0]  m1_wb_cti_o = '0;
  logic [1:0]  m1_wb_bte_o = '0;
  logic [31:0] m1_wb_dat_i;
  logic        m1_wb_ack_i, m1_wb_err_i, m1_wb_rty_i;
  logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o;
  logic [3:0]  s_wb_sel_o;
  logic [2:0]  s_wb_cti_o;
  logic [1:0]  s_wb_bte_o;
  logic [31:0] s_wb_dat_i;
  logic        s_wb_ack_i;
  logic        s_wb_err_i = 1'b0, s_wb_rty_i = 1'b0;
  logic [1:0]  grant;
  logic        timeout_evt;

  wb_mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_wb_cyc_o(m0_wb_cyc_o), .m0_wb_stb_o(m0_wb_stb_o), .m0_wb_we_o(m0_wb_we_o),
    .m0_wb_adr_o(m0_wb_adr_o), .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_sel_o(m0_wb_sel_o),
    .m0_wb_cti_o(m0_wb_cti_o), .m0_wb_bte_o(m0_wb_bte_o), .m0_wb_dat_i(m0_wb_dat_i),
    .m0_wb_ack_i(m0_wb_ack_i), .m0_wb_err_i(m0_wb_err_i), .m0_wb_rty_i(m0_wb_rty_i),
    .m1_wb_cyc_o(m1_wb_cyc_o), .m1_wb_stb_o(m1_wb_stb_o), .m1_wb_we_o(m1_wb_we_o),
    .m1_wb_adr_o(m1_wb_adr_o), .m1_wb_dat_o(m1_wb_dat_o), .m1_wb_sel_o(m1_wb_sel_o),
    .m1_wb_cti_o(m1_wb_cti_o), .m1_wb_bte_o(m1_wb_bte_o), .m1_wb_dat_i(m1_wb_dat_i),
    .m1_wb_ack_i(m1_wb_ack_i), .m1_wb_err_i(m1_wb_err_i), .m1_wb_rty_i(m1_wb_rty_i),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_cti_o(s_wb_cti_o), .s_wb_bte_o(s_wb_bte_o), .s_wb_dat_i(s_wb_dat_i),
    .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i), .s_wb_rty_i(s_wb_rty_i),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  // Slave model: ack one cycle after a strobe, data is a fixed function of address.
  function automatic logic [31:0] slave_data(input logic [31:0] adr);
    if (adr == 32'h0000_0100) return 32'hDEAD_BEEF;
    return adr ^ 32'hA5A5_0000;
  endfunction

  logic        slave_en = 1'b1;
  logic        forced_ack = 1'b0;
  logic        s_ack_r = 1'b0;
  logic [31:0] s_dat_r = '0;
  assign s_wb_ack_i = s_ack_r | forced_ack;
  assign s_wb_dat_i = s_dat_r;

  always @(posedge clk) begin
    s_ack_r <= slave_en && s_wb_cyc_o && s_wb_stb_o && !s_ack_r;
    if (slave_en && s_wb_cyc_o && s_wb_stb_o && !s_ack_r) s_dat_r <= slave_data(s_wb_adr_o);
  end

  typedef struct packed {
    logic        ack0, err0, ack1, err1, tevt;
    logic [31:0] dat;
  } ev_t;
  typedef struct packed {
    bit  chk;
    ev_t ev;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] gq[$];
  int         checks = 0;
  int         failures = 0;
  bit         mon_on = 0;
  logic [1:0] prev_g = 2'b00;
  ev_t        obs;
  exp_t       e;
  logic [1:0] g_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t ack_of(input int m, input logic [31:0] dat);
    exp_t x;
    x = '0;
    x.chk = 1'b1;
    x.ev.ack0 = (m == 0);
    x.ev.ack1 = (m == 1);
    x.ev.dat = dat;
    return x;
  endfunction

  task automatic drive(input int m, input logic c, input logic [31:0] adr, input logic [2:0] cti);
    if (m == 0) begin
      m0_wb_cyc_o = c; m0_wb_stb_o = c; m0_wb_adr_o = adr; m0_wb_cti_o = cti;
    end else begin
      m1_wb_cyc_o = c; m1_wb_stb_o = c; m1_wb_adr_o = adr; m1_wb_cti_o = cti;
    end
  endtask

  task automatic wait_ack(input int m, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_wb_ack_i : m1_wb_ack_i) begin
        ok = 1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL ack_wait_m%0d actual=no_ack required=ack_within_40", m);
  endtask

  // Called aligned to just after a rising edge; returns with cyc dropped.
  task automatic xfer(input int m, input logic [31:0] adr, input int beats);
    bit ok;
    logic [2:0] cti;
    for (int b = 0; b < beats; b++) begin
      cti = (beats == 1) ? CLASSIC : ((b == beats - 1) ? EOB : INCR);
      drive(m, 1'b1, adr + 32'(4 * b), cti);
      wait_ack(m, ok);
      if (ok) begin
        check("cti_pass", 64'(s_wb_cti_o), 64'(cti));
        check("adr_pass", 64'(s_wb_adr_o), 64'(adr + 32'(4 * b)));
      end
      @(posedge clk); #1;
    end
    drive(m, 1'b0, '0, CLASSIC);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok, hit;
    int k;
    exp_t x;

    fork
      forever begin
        @(negedge clk);
        if (mon_on) begin
          obs.ack0 = m0_wb_ack_i; obs.err0 = m0_wb_err_i;
          obs.ack1 = m1_wb_ack_i; obs.err1 = m1_wb_err_i;
          obs.tevt = timeout_evt;
          obs.dat  = m1_wb_ack_i ? m1_wb_dat_i : m0_wb_dat_i;
          if (obs.ack0 | obs.err0 | obs.ack1 | obs.err1 | obs.tevt) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_resp actual=%0h required=none", obs);
            end else begin
              e = exp_q.pop_front();
              if (!e.chk) begin
                obs.dat = '0;
                e.ev.dat = '0;
              end
              check("resp", 64'(obs), 64'(e.ev));
            end
          end
          if (grant !== prev_g) begin
            if (gq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_grant actual=%b required=none", grant);
            end else begin
              g_exp = gq.pop_front();
              check("grant_seq", 64'(grant), 64'(g_exp));
            end
            prev_g = grant;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ctrl", 64'({grant, timeout_evt, s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o,
                           s_wb_cti_o, s_wb_bte_o, m0_wb_ack_i, m0_wb_err_i, m0_wb_rty_i,
                           m1_wb_ack_i, m1_wb_err_i, m1_wb_rty_i}), 64'h0);
    check("rst_adr_dat", {s_wb_adr_o, s_wb_dat_o}, 64'h0);
    mon_on = 1;
    @(posedge clk); #1;

    // Single master m0 classic read of 0x100
    gq.push_back(2'b01); gq.push_back(2'b00);
    exp_q.push_back(ack_of(0, 32'hDEAD_BEEF));
    drive(0, 1'b1, 32'h0000_0100, CLASSIC);
    @(negedge clk);
    check("t1_no_grant_same_cycle", 64'(grant), 64'h0);
    @(negedge clk);
    check("t1_grant_next_cycle", 64'({grant, s_wb_cyc_o, s_wb_stb_o}), 64'b0111);
    wait_ack(0, ok);
    if (ok) check("t1_m1_quiet", 64'({m1_wb_ack_i, m1_wb_err_i}), 64'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, CLASSIC);
    repeat (3) @(posedge clk); #1;

    // Simultaneous requests after reset: m0 first, m1 with no idle between
    reset_dut();
    gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b00);
    exp_q.push_back(ack_of(0, slave_data(32'h400)));
    exp_q.push_back(ack_of(1, slave_data(32'h500)));
    fork
      xfer(0, 32'h400, 1);
      xfer(1, 32'h500, 1);
    join
    repeat (3) @(posedge clk); #1;

    // Fairness: three transfers each, continuous requests
    for (int i = 0; i < 3; i++) begin
      gq.push_back(2'b01); gq.push_back(2'b10);
      exp_q.push_back(ack_of(0, slave_data(32'h1000 + 32'(4 * i))));
      exp_q.push_back(ack_of(1, slave_data(32'h2000 + 32'(4 * i))));
    end
    gq.push_back(2'b00);
    fork
      for (int i = 0; i < 3; i++) begin
        xfer(0, 32'h1000 + 32'(4 * i), 1);
        @(posedge clk); #1;
      end
      for (int j = 0; j < 3; j++) begin
        xfer(1, 32'h2000 + 32'(4 * j), 1);
        @(posedge clk); #1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Burst integrity: m1 8-beat INCR burst, m0 requests mid-burst
    gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b00);
    for (int b = 0; b < 8; b++) exp_q.push_back(ack_of(1, slave_data(32'h3000 + 32'(4 * b))));
    exp_q.push_back(ack_of(0, slave_data(32'h4000)));
    fork
      xfer(1, 32'h3000, 8);
      begin
        repeat (5) @(posedge clk); #1;
        xfer(0, 32'h4000, 1);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Timeout: slave silent, err + timeout_evt in the 16th stalled cycle
    slave_en = 1'b0;
    gq.push_back(2'b01); gq.push_back(2'b00);
    x = '0; x.ev.err0 = 1'b1; x.ev.tevt = 1'b1;
    exp_q.push_back(x);
    drive(0, 1'b1, 32'h600, CLASSIC);
    k = 0;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant == 2'b01) k++;
      if (m0_wb_err_i) begin
        hit = 1;
        check("to_cycle", 64'(k), 64'd16);
        check("to_stb_forced_low", 64'(s_wb_stb_o), 64'h0);
        break;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL to_fire actual=no_err required=err_in_cycle_16");
    end
    @(negedge clk);
    check("to_pulse_width", 64'({m0_wb_err_i, timeout_evt}), 64'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, CLASSIC);
    repeat (2) @(posedge clk); #1;

    // Timeout: ack in the would-be firing cycle wins
    gq.push_back(2'b01); gq.push_back(2'b00);
    x = '0; x.ev.ack0 = 1'b1;
    exp_q.push_back(x);
    drive(0, 1'b1, 32'h700, CLASSIC);
    repeat (16) @(posedge clk);
    #1 forced_ack = 1'b1;
    @(negedge clk);
    check("to_ack_wins", 64'({m0_wb_ack_i, m0_wb_err_i, timeout_evt}), 64'b100);
    @(posedge clk); #1;
    forced_ack = 1'b0;
    drive(0, 1'b0, '0, CLASSIC);
    slave_en = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Reset in beat 3 of an m0 write burst, then a tie goes to m0
    gq.push_back(2'b01); gq.push_back(2'b00);
    exp_q.push_back(ack_of(0, slave_data(32'h800)));
    exp_q.push_back(ack_of(0, slave_data(32'h804)));
    m0_wb_we_o = 1'b1;
    drive(0, 1'b1, 32'h800, INCR);
    wait_ack(0, ok);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h804, INCR);
    wait_ack(0, ok);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h808, INCR);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ctrl", 64'({grant, timeout_evt, s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o,
                              s_wb_cti_o, s_wb_bte_o, m0_wb_ack_i, m0_wb_err_i}), 64'h0);
    check("rstmid_adr_dat", {s_wb_adr_o, s_wb_dat_o}, 64'h0);
    #1;
    drive(0, 1'b0, '0, CLASSIC);
    m0_wb_we_o = 1'b0;
    repeat (3) @(posedge clk); #1;
    gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b00);
    exp_q.push_back(ack_of(0, slave_data(32'h900)));
    exp_q.push_back(ack_of(1, slave_data(32'hA00)));
    fork
      xfer(0, 32'h900, 1);
      xfer(1, 32'hA00, 1);
    join
    repeat (3) @(posedge clk);

    @(negedge clk);
    check("resp_queue_drained", 64'(exp_q.size()), 64'h0);
    check("grant_queue_drained", 64'(gq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
